// File: rtl/mips_alu_seq.sv
// Sequential MIPS EX-stage ALU: single-cycle arithmetic/logic ops with registered
// results, plus iterative unsigned multiply and restoring divide writing HI/LO.
module mips_alu_seq #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Cout,
    output logic             ZF,
    output logic             OF,
    output logic             DZ
);
    localparam int M = WIDTH - 1;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, cout_q, cout_d, zf_q, zf_d, of_q, of_d, dz_q, dz_d;

    logic [WIDTH:0]     add_s, sub_s, mul_sum, div_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge, last;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, step_nxt;

    assign add_s = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign sub_s = {1'b0, A} - {1'b0, B};

    // Multiply: acc = {partial, multiplier}; add multiplicand to the top half, shift right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign mul_nxt = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; B=0 naturally yields all-ones / A.
    assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = div_sh >= {1'b0, b_q};
    assign div_diff = div_sh[WIDTH-1:0] - b_q;
    assign div_nxt  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                             : {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign step_nxt = (state_q == S_MUL) ? mul_nxt : div_nxt;
    assign last     = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) begin
                if (opr == OP_MULTU)     state_d = S_MUL;
                else if (opr == OP_DIVU) state_d = S_DIV;
            end
            S_MUL, S_DIV: if (last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        Res  = res_q;
        HI   = hi_q;
        LO   = lo_q;
        Cout = cout_q;
        ZF   = zf_q;
        OF   = of_q;
        DZ   = dz_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        b_d    = b_q;
        res_d  = res_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        cout_d = cout_q;
        zf_d   = zf_q;
        of_d   = of_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                if (opr == OP_MULTU || opr == OP_DIVU) begin
                    acc_d = {{WIDTH{1'b0}}, A};
                    b_d   = B;
                    cnt_d = CW'(WIDTH);
                end else begin
                    done_d = 1'b1;
                    cout_d = 1'b0;
                    of_d   = 1'b0;
                    dz_d   = 1'b0;
                    res_d  = '0;
                    case (opr)
                        OP_ADD: begin
                            res_d  = add_s[WIDTH-1:0];
                            cout_d = add_s[WIDTH];
                            of_d   = (A[M] == B[M]) && (add_s[M] != A[M]);
                        end
                        OP_SUB: begin
                            res_d  = sub_s[WIDTH-1:0];
                            cout_d = sub_s[WIDTH];
                            of_d   = (A[M] != B[M]) && (sub_s[M] != A[M]);
                        end
                        OP_AND:  res_d = A & B;
                        OP_OR:   res_d = A | B;
                        OP_XOR:  res_d = A ^ B;
                        OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
                        OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, A < B};
                        default: res_d = '0;
                    endcase
                    zf_d = (res_d == '0);
                end
            end
            S_MUL, S_DIV: begin
                acc_d = step_nxt;
                cnt_d = cnt_q - CW'(1);
                if (last) begin
                    hi_d   = step_nxt[2*WIDTH-1:WIDTH];
                    lo_d   = step_nxt[WIDTH-1:0];
                    res_d  = step_nxt[WIDTH-1:0];
                    zf_d   = (step_nxt[WIDTH-1:0] == '0);
                    cout_d = 1'b0;
                    of_d   = 1'b0;
                    dz_d   = (state_q == S_DIV) && (b_q == '0);
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            res_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            cout_q <= 1'b0;
            zf_q   <= 1'b0;
            of_q   <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            b_q    <= b_d;
            res_q  <= res_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            cout_q <= cout_d;
            zf_q   <= zf_d;
            of_q   <= of_d;
            dz_q   <= dz_d;
        end
    end
endmodule

// File: doc/mips_alu_seq.md
# mips_alu_seq

Parametrised, clocked successor to the combinational 32-bit ALU in the MIPS datapath. Adds registered results, a start/busy/done handshake, true signed overflow, SLTU/XOR, and iterative unsigned multiply and divide writing a HI/LO pair. It sits in the EX stage. Single-cycle ops complete in one clock; MULTU/DIVU stall the pipeline via `busy`.

## Interface
- WIDTH, 32, operand/result width (≥4, even)
- CW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request; sampled only when busy=0
- opr  in  4  op: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 SLT (signed), 0110 SLTU, 0111 XOR, 1000 MULTU, 1001 DIVU; others invalid
- A, B  in  WIDTH  operands
- Cin  in  1  carry-in, ADD only
- busy  out  1  iterative op in progress
- done  out  1  one-cycle completion pulse
- Res  out  WIDTH  result (LO for MULTU/DIVU)
- HI, LO  out  WIDTH  mul: product high/low; div: remainder/quotient
- Cout  out  1  ADD carry-out; SUB borrow (A<B unsigned)
- ZF  out  1  Res==0
- OF  out  1  signed overflow, ADD/SUB only
- DZ  out  1  DIVU with B==0

## Operation
- FSM states IDLE, MUL, DIV; busy = (state != IDLE).
- IDLE, start=1, single-cycle op: result computed from A/B/Cin in that cycle and registered. Next cycle: done=1; Res/flags valid. State stays IDLE, so a new start is accepted every cycle.
- ADD: {Cout,Res} = A+B+Cin, WIDTH+1-bit sum. OF = (A[msb]==B[msb]) && (Res[msb]!=A[msb]).
- SUB: {Cout,Res} = A-B in WIDTH+1 bits. Cout=1 iff A<B unsigned. OF = (A[msb]!=B[msb]) && (Res[msb]!=A[msb]).
- AND/OR/XOR/SLT/SLTU: Cout=0, OF=0. SLT/SLTU Res is 1 or 0, zero-extended.
- MULTU: latch A, B. Counter = WIDTH. Go to MUL. One shift-add step per cycle on a 2·WIDTH accumulator.
- DIVU: latch A, B. Counter = WIDTH. Go to DIV. One restoring shift-subtract step per cycle.
- Divide-by-zero is not special-cased in the datapath: B=0 naturally yields LO=all-ones and HI=A. DZ=1 for that op. The op still takes the full latency.
- On the final iteration (counter==1), write HI/LO and Res=LO, then return to IDLE. done pulses in the following cycle. ZF reflects Res only; Cout=OF=0.
- Invalid opr with start: done pulses next cycle, Res=0, ZF=1, Cout=OF=DZ=0.
- start while busy=1: ignored, with no effect on state or outputs.
- Outputs not written by an op keep their values. Res/ZF/Cout/OF/DZ update only on op completion. HI/LO update only on MULTU/DIVU completion.

## Timing
- Reset (rst_n=0 at an edge) clears state to IDLE and the counter to 0. busy, done, Res, HI, LO, Cout, ZF, OF and DZ all become 0.
- Reset asserted mid-MUL/DIV aborts the op with no done pulse. The unit is ready in the first cycle after rst_n=1.
- Single-cycle latency: start in cycle t gives done=1 and valid Res in cycle t+1.
- Iterative latency: start in cycle t gives busy=1 in cycles t+1..t+WIDTH. In cycle t+WIDTH+1, done=1, busy=0 and results are valid. A new start is accepted in that same cycle.
- done is never high for two consecutive cycles from one request. Back-to-back single-cycle ops give consecutive done pulses, one per request.
- A/B/opr only need to be stable in the start cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles mid-MULTU -> all outputs 0, no done. After release, ADD 1+1 -> done at t+1, Res=2.
- ADD/SUB flags:
  - ADD 0x7FFFFFFF+1, Cin=0 -> Res=0x80000000, OF=1, Cout=0.
  - ADD 0xFFFFFFFF+1 -> Res=0, ZF=1, Cout=1, OF=0.
  - SUB 3-5 -> Res=0xFFFFFFFE, Cout=1, OF=0.
- Compares: SLT 0xFFFFFFFF,1 -> Res=1; SLTU same operands -> Res=0. Issued back-to-back -> done on two consecutive cycles.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> busy for 32 cycles, then done at t+33 with HI=0xFFFFFFFE, LO=0x00000001, Res=1. A start issued mid-op is ignored.
- DIVU 100/7 -> LO=14, HI=2, DZ=0. DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234, DZ=1, done at t+33.
- Sweep WIDTH=8: random ops vs a reference model. opr=1111 -> done, Res=0, ZF=1.
